// File: rtl/cordic_mux_pkg.sv
// Shared definitions for the CORDIC channel selector / demultiplexer pair.
// Select coding is common to the 3:1 selector and the 1:3 demux.
package cordic_mux_pkg;

  // Destination / source select codes
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_CH0  = 2'b01;
  localparam logic [1:0] SEL_CH1  = 2'b10;
  localparam logic [1:0] SEL_CH2  = 2'b11;

  localparam int NUM_CH     = 3;
  localparam int DROP_CNT_W = 16;

  // One-entry output slot occupancy
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Select code to one-hot channel mask; SEL_NONE targets no channel
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (sel)
      SEL_CH0: oh = 3'b001;
      SEL_CH1: oh = 3'b010;
      SEL_CH2: oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  // Saturating increment for the drop counter
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready register stage: load, drain, stall.
// The parent only asserts load when room is high, so FULL+load
// always coincides with a drain and the slot stays FULL.
module demux_slot
  import cordic_mux_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic         room,
  output logic [W-1:0] data
);

  slot_state_e state_q, state_d;

  // Occupancy register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SLOT_EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy: load fills, drain without load empties
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (load)           state_d = SLOT_FULL;
      SLOT_FULL:  if (!load && ready) state_d = SLOT_EMPTY;
      default:                        state_d = SLOT_EMPTY;
    endcase
  end

  // Handshake outputs; room is combinational from downstream ready
  always_comb begin
    valid = (state_q == SLOT_FULL);
    room  = (state_q == SLOT_EMPTY) || ready;
  end

  // Data register only moves on load, so it holds through a stall
  always_ff @(posedge clk) begin
    if (rst)       data <= '0;
    else if (load) data <= din;
  end

endmodule

// File: rtl/demux_1x3_reg.sv
// Registered 1:3 demultiplexer with per-channel one-entry output slots.
// Optional: define DEMUX_DROP_CNT_EN to add a saturating count of
// words accepted with the SEL_NONE code (drop_count port).
module demux_1x3_reg
  import cordic_mux_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            select,
  input  logic [W-1:0]          data_in,
  output logic                  ch_0_valid,
  output logic                  ch_1_valid,
  output logic                  ch_2_valid,
  input  logic                  ch_0_ready,
  input  logic                  ch_1_ready,
  input  logic                  ch_2_ready,
  output logic [W-1:0]          ch_0_data,
  output logic [W-1:0]          ch_1_data,
  output logic [W-1:0]          ch_2_data
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_count
`endif
);

  logic [NUM_CH-1:0]        sel_oh;
  logic [NUM_CH-1:0]        slot_load;
  logic [NUM_CH-1:0]        slot_ready;
  logic [NUM_CH-1:0]        slot_valid;
  logic [NUM_CH-1:0]        slot_room;
  logic [NUM_CH-1:0][W-1:0] slot_data;
  logic                     xfer;

  assign slot_ready = {ch_2_ready, ch_1_ready, ch_0_ready};

  // Select decode and in_ready mux; SEL_NONE always accepts
  always_comb begin
    sel_oh   = sel_onehot(select);
    in_ready = 1'b1;
    case (select)
      SEL_CH0: in_ready = slot_room[0];
      SEL_CH1: in_ready = slot_room[1];
      SEL_CH2: in_ready = slot_room[2];
      default: in_ready = 1'b1;
    endcase
    xfer      = in_valid && in_ready;
    slot_load = xfer ? sel_oh : '0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (slot_load[i]),
      .din   (data_in),
      .ready (slot_ready[i]),
      .valid (slot_valid[i]),
      .room  (slot_room[i]),
      .data  (slot_data[i])
    );
  end

  assign ch_0_valid = slot_valid[0];
  assign ch_1_valid = slot_valid[1];
  assign ch_2_valid = slot_valid[2];
  assign ch_0_data  = slot_data[0];
  assign ch_1_data  = slot_data[1];
  assign ch_2_data  = slot_data[2];

`ifdef DEMUX_DROP_CNT_EN
  // Saturating count of discarded (SEL_NONE) transfers
  always_ff @(posedge clk) begin
    if (rst)                             drop_count <= '0;
    else if (xfer && select == SEL_NONE) drop_count <= sat_inc(drop_count);
  end
`endif

endmodule
